lbus_dma_master: RTL and testbench

- Local-bus initiator that copies a block of 32-bit words from a source to a destination byte address.
- Drives the same addr/qin/we signals the local-bus decoder consumes, and samples its qout.
- Sits beside the CPU data port behind a bus arbiter: requests via bus_req, drives the bus only while bus_gnt=1.
- Started by a peripheral register block; reports busy/done.

---
 rtl/lbus_dma_master_pkg.sv | 19 +
 rtl/lbus_dma_master.sv | 165 ++++++++++++++++
 tb/tb_lbus_dma_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lbus_dma_master_pkg.sv
// Shared definitions for the local-bus DMA master.
// - DefaultXlen : bus data/address width used by the core
// - WordInc     : byte stride between consecutive 32-bit words
// - dma_state_e : controller state encoding (3-bit)
package lbus_dma_master_pkg;

  localparam int unsigned DefaultXlen = 32;
  localparam int unsigned WordInc     = 4;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StRd   = 3'd2,
    StCap  = 3'd3,
    StWr   = 3'd4,
    StFin  = 3'd5
  } dma_state_e;

endpackage

// File: rtl/lbus_dma_master.sv
// Local-bus DMA master: copies len_words 32-bit words from src_addr to dst_addr
// through the same addr/qin/we/qout interface the local-bus decoder uses.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle start pulse (honoured only when idle)
//   src_addr, dst_addr  byte addresses, low two bits ignored
//   len_words           number of words to copy (0 = finish without bus access)
//   abort               stop after the current word's write
//   busy, done, aborted status towards the register block
//   bus_req, bus_gnt    arbiter handshake
//   addr, qin, we, qout local-bus master signals
// All outputs are registered. Bus outputs are loaded on the edge that enters a
// state, so they line up with the state they belong to; done/aborted are
// loaded on the edge that leaves FIN.
module lbus_dma_master
  import lbus_dma_master_pkg::*;
#(
  parameter int unsigned XLEN   = DefaultXlen,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [XLEN-1:0]  src_addr,
  input  logic [XLEN-1:0]  dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [XLEN-1:0]  addr,
  output logic [XLEN-1:0]  qin,
  output logic [3:0]       we,
  input  logic [XLEN-1:0]  qout
);

  localparam int unsigned    LatW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LatW-1:0] LatInit = LatW'(RD_LAT - 1);
  localparam logic [XLEN-1:0] Inc     = XLEN'(WordInc);
  localparam logic [XLEN-1:0] AlignMask = ~XLEN'(3);

  dma_state_e       state_q;
  logic [XLEN-1:0]  src_q, dst_q, data_q, addr_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LatW-1:0]  lat_q;
  logic             abort_q;
  logic             busy_q, done_q, aborted_q, bus_req_q;
  logic [3:0]       we_q;

  logic [XLEN-1:0]  src_nxt, dst_nxt;
  logic             last_word;

  // Addresses wrap silently modulo 2^XLEN.
  assign src_nxt   = src_q + Inc;
  assign dst_nxt   = dst_q + Inc;
  // Evaluated in WR: the word being written is the last one, or an abort has
  // been seen at any point during this word (including this very cycle).
  assign last_word = (cnt_q == LEN_W'(1)) || abort_q || abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      bus_req_q <= 1'b0;
      we_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // abort is ignored here, so start always wins over a coincident abort.
          if (start) begin
            src_q     <= src_addr & AlignMask;
            dst_q     <= dst_addr & AlignMask;
            cnt_q     <= len_words;
            aborted_q <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b1;
            if (len_words == '0) begin
              state_q <= StFin;
            end else begin
              state_q   <= StReq;
              bus_req_q <= 1'b1;
            end
          end
        end
        StReq: begin
          if (abort) begin
            abort_q   <= 1'b1;
            bus_req_q <= 1'b0;
            state_q   <= StFin;
          end else if (bus_gnt) begin
            state_q <= StRd;
            addr_q  <= src_q;
            lat_q   <= LatInit;
          end
        end
        StRd: begin
          if (abort) abort_q <= 1'b1;
          if (lat_q == '0) begin
            state_q <= StCap;
          end else begin
            lat_q <= lat_q - LatW'(1);
          end
        end
        StCap: begin
          // qout is valid this cycle; the data register also drives qin in WR.
          if (abort) abort_q <= 1'b1;
          data_q  <= qout;
          addr_q  <= dst_q;
          we_q    <= 4'hF;
          state_q <= StWr;
        end
        StWr: begin
          if (abort) abort_q <= 1'b1;
          src_q  <= src_nxt;
          dst_q  <= dst_nxt;
          cnt_q  <= cnt_q - LEN_W'(1);
          data_q <= '0;
          we_q   <= '0;
          if (last_word) begin
            bus_req_q <= 1'b0;
            addr_q    <= '0;
            state_q   <= StFin;
          end else if (bus_gnt) begin
            addr_q  <= src_nxt;
            lat_q   <= LatInit;
            state_q <= StRd;
          end else begin
            addr_q  <= '0;
            state_q <= StReq;
          end
        end
        StFin: begin
          done_q    <= 1'b1;
          aborted_q <= abort_q;
          busy_q    <= 1'b0;
          bus_req_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign bus_req = bus_req_q;
  assign addr    = addr_q;
  assign qin     = data_q;
  assign we      = we_q;

endmodule

// File: tb/tb_lbus_dma_master.sv
// Self-checking bench for lbus_dma_master: RAM model on the local bus, expected
// writes queued at stimulus time and popped when the DUT writes.
module tb_lbus_dma_master;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned RD_LAT = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [XLEN-1:0]  src_addr, dst_addr;
  logic [LEN_W-1:0] len_words;
  logic             abort;
  logic             busy, done, aborted, bus_req, bus_gnt;
  logic [XLEN-1:0]  addr, qin, qout;
  logic [3:0]       we;

  always #5 clk = ~clk;

  lbus_dma_master #(
    .XLEN  (XLEN),
    .LEN_W (LEN_W),
    .RD_LAT(RD_LAT)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len_words(len_words),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .addr     (addr),
    .qin      (qin),
    .we       (we),
    .qout     (qout)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         got_w;
  int unsigned n_pushed = 0;
  logic [31:0] mem [logic [31:0]];

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
    n_pushed++;
  endtask

  // RAM model, read latency of one cycle.
  always @(posedge clk) begin
    qout <= mem.exists(addr) ? mem[addr] : 32'h0;
    if (we == 4'hF) mem[addr] = qin;
  end

  // Bus monitor.
  int unsigned n_wr = 0, n_req = 0, n_done = 0, n_idle_drive = 0, n_nogrant = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_req) n_req++;
      if (done) n_done++;
      if (!busy && (bus_req || addr != 0 || we != 0 || qin != 0)) n_idle_drive++;
      if (we == 0 && qin != 0) n_idle_drive++;
      if (!bus_gnt && (addr != 0 || we != 0)) n_nogrant++;
      if (we != 0) begin
        n_wr++;
        if (exp_q.size() == 0) begin
          check_eq("wr_extra", n_wr, n_pushed);
        end else begin
          got_w = exp_q.pop_front();
          check_eq("wr_addr", addr, got_w.a);
          check_eq("wr_data", qin, got_w.d);
          check_eq("wr_we", {28'h0, we}, 32'hF);
        end
      end
    end
  end

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(posedge clk); #1;
    src_addr  = s;
    dst_addr  = d;
    len_words = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle counter c0 is the cycle index on entry; returns the index of the done cycle.
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) check_eq("done_timeout", {31'h0, done}, 32'h1);
  endtask

  int cyc;
  int c;
  int unsigned r0, w0, d0, seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bus_gnt = 1'b1;
    src_addr = '0; dst_addr = '0; len_words = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_done", {31'h0, done}, 32'h0);
    check_eq("rst_req", {31'h0, bus_req}, 32'h0);
    check_eq("rst_addr", addr, 32'h0);
    check_eq("rst_we", {28'h0, we}, 32'h0);
    rst_n = 1'b1;

    // len = 0: done two cycles after start, no bus activity
    r0 = n_req; w0 = n_wr;
    pulse_start(32'h100, 32'h200, 16'd0);
    wait_done(1, cyc);
    check_eq("len0_cycles", cyc, 2);
    check_eq("len0_req", n_req - r0, 0);
    check_eq("len0_wr", n_wr - w0, 0);

    // Basic copy
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h104] = 32'h12345678;
    push_wr(32'h200, 32'hDEADBEEF);
    push_wr(32'h204, 32'h12345678);
    pulse_start(32'h100, 32'h200, 16'd2);
    wait_done(1, cyc);
    check_eq("basic_cycles", cyc, 9);
    check_eq("basic_aborted", {31'h0, aborted}, 32'h0);
    check_eq("basic_busy_at_done", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    check_eq("basic_done_pulse", {31'h0, done}, 32'h0);
    check_eq("basic_pending", exp_q.size(), 0);

    // Grant stall: grant withheld for five cycles
    bus_gnt = 1'b0;
    mem[32'h140] = 32'hA5A5_0001;
    mem[32'h144] = 32'h5A5A_0002;
    push_wr(32'h300, 32'hA5A5_0001);
    push_wr(32'h304, 32'h5A5A_0002);
    pulse_start(32'h140, 32'h300, 16'd2);
    check_eq("stall_req", {31'h0, bus_req}, 32'h1);
    check_eq("stall_addr", addr, 32'h0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_eq("stall_req_held", {31'h0, bus_req}, 32'h1);
    bus_gnt = 1'b1;
    wait_done(5, cyc);
    check_eq("stall_cycles", cyc, 13);
    check_eq("stall_pending", exp_q.size(), 0);

    // Misaligned source, destination wraps
    mem[32'h100] = 32'hCAFEF00D;
    mem[32'h104] = 32'h0BADC0DE;
    push_wr(32'hFFFF_FFFC, 32'hCAFEF00D);
    push_wr(32'h0000_0000, 32'h0BADC0DE);
    pulse_start(32'h103, 32'hFFFF_FFFC, 16'd2);
    wait_done(1, cyc);
    check_eq("wrap_cycles", cyc, 9);
    check_eq("wrap_pending", exp_q.size(), 0);

    // Abort during the third word's read
    for (int i = 0; i < 10; i++) mem[32'h400 + 4 * i] = 32'h1000 + i;
    for (int i = 0; i < 3; i++) push_wr(32'h800 + 4 * i, 32'h1000 + i);
    pulse_start(32'h400, 32'h800, 16'd10);
    c = 1;
    while (!(addr == 32'h408 && we == 4'h0) && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq("abort_rd_addr", addr, 32'h408);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    c++;
    wait_done(c, cyc);
    check_eq("abort_cycles", cyc, 12);
    check_eq("abort_flag", {31'h0, aborted}, 32'h1);
    check_eq("abort_pending", exp_q.size(), 0);

    // Restart clears aborted
    mem[32'h440] = 32'h7777_8888;
    push_wr(32'h900, 32'h7777_8888);
    pulse_start(32'h440, 32'h900, 16'd1);
    check_eq("restart_aborted_clr", {31'h0, aborted}, 32'h0);
    wait_done(1, cyc);
    check_eq("restart_cycles", cyc, 6);
    check_eq("restart_aborted", {31'h0, aborted}, 32'h0);

    // start while busy is ignored
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h104] = 32'h12345678;
    mem[32'h500] = 32'hBAD0_0000;
    push_wr(32'hA00, 32'hDEADBEEF);
    push_wr(32'hA04, 32'h12345678);
    pulse_start(32'h100, 32'hA00, 16'd2);
    @(posedge clk); #1;
    src_addr = 32'h500; dst_addr = 32'h600; len_words = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, cyc);
    check_eq("ignore_cycles", cyc, 9);
    check_eq("ignore_pending", exp_q.size(), 0);

    // Reset during the second word's write
    mem[32'h180] = 32'h0000_0A0A;
    mem[32'h184] = 32'h0000_0B0B;
    mem[32'h188] = 32'h0000_0C0C;
    mem[32'hB04] = 32'h0;
    push_wr(32'hB00, 32'h0000_0A0A);
    pulse_start(32'h180, 32'hB00, 16'd3);
    seen = 0;
    c = 1;
    while (c < 100) begin
      if (we != 0) seen++;
      if (seen == 2) break;
      @(posedge clk); #1;
      c++;
    end
    check_eq("rst_mid_seen", seen, 2);
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_mid_req", {31'h0, bus_req}, 32'h0);
    check_eq("rst_mid_addr", addr, 32'h0);
    check_eq("rst_mid_qin", qin, 32'h0);
    check_eq("rst_mid_we", {28'h0, we}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_mid_no_done", n_done - d0, 0);
    check_eq("rst_mid_busy_after", {31'h0, busy}, 32'h0);
    check_eq("rst_mid_no_write", mem[32'hB04], 32'h0);

    check_eq("final_pending", exp_q.size(), 0);
    check_eq("idle_bus_driven", n_idle_drive, 0);
    check_eq("nogrant_bus_driven", n_nogrant, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
